// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-back, write-allocate line cache
// with tree pseudo-LRU replacement.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   mem_address         CPU byte address (offset bits ignored)
//   mem_read/mem_write  CPU request, held until mem_resp (write wins if both)
//   mem_byte_enable256  per-byte write enable
//   mem_wdata256        CPU write line
//   mem_rdata256        read line, valid only with mem_resp on a read
//   mem_resp            one-cycle completion pulse
//   pmem_address        line-aligned memory address (WB/FILL only)
//   pmem_read/write     memory fill / writeback request, held until pmem_resp
//   pmem_wdata          writeback line
//   pmem_rdata          fill line
//   pmem_resp           memory completion pulse
//
// Outputs are decoded from the registered state so that rst drops them at once.
module assoc_cache #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned num_ways = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 mem_address,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [(2**s_offset)-1:0]    mem_byte_enable256,
    input  logic [(8*2**s_offset)-1:0]  mem_wdata256,
    output logic [(8*2**s_offset)-1:0]  mem_rdata256,
    output logic                        mem_resp,
    output logic [31:0]                 pmem_address,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [(8*2**s_offset)-1:0]  pmem_wdata,
    input  logic [(8*2**s_offset)-1:0]  pmem_rdata,
    input  logic                        pmem_resp
);

    localparam int unsigned s_tag     = 32 - s_offset - s_index;
    localparam int unsigned num_sets  = 2**s_index;
    localparam int unsigned num_bytes = 2**s_offset;
    localparam int unsigned line_w    = 8 * num_bytes;
    localparam int unsigned way_w     = $clog2(num_ways);
    localparam int unsigned lru_w     = num_ways - 1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WB,
        FILL
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [way_w-1:0]    victim_q, victim_d;

    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];
    logic [lru_w-1:0]    lru_q   [num_sets];
    logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
    logic [line_w-1:0]   data_q  [num_sets][num_ways];

    logic [s_tag-1:0]    addr_tag;
    logic [s_index-1:0]  addr_idx;
    logic                unused_offset;

    logic                hit_c;
    logic [way_w-1:0]    hit_way_c;
    logic [line_w-1:0]   hit_line_c;
    logic [line_w-1:0]   merged_c;
    logic [lru_w-1:0]    lru_cur_c;
    logic [lru_w-1:0]    lru_upd_c;
    logic [way_w-1:0]    lru_way_c;
    logic                inv_found_c;
    logic [way_w-1:0]    inv_way_c;
    logic [way_w-1:0]    victim_c;

    logic                line_we;
    logic [way_w-1:0]    line_way;
    logic [line_w-1:0]   line_wdata;
    logic                fill_done;
    logic                hit_upd;

    assign addr_tag      = mem_address[31 -: s_tag];
    assign addr_idx      = mem_address[s_offset +: s_index];
    assign unused_offset = ^mem_address[s_offset-1:0];
    assign lru_cur_c     = lru_q[addr_idx];
    assign hit_line_c    = data_q[addr_idx][hit_way_c];

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (valid_q[addr_idx][w] && (tag_q[addr_idx][w] == addr_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = way_w'(w);
            end
        end
    end

    // Byte-enable merge of the CPU write into the hit line
    always_comb begin
        merged_c = hit_line_c;
        for (int b = 0; b < num_bytes; b++) begin
            if (mem_byte_enable256[b]) begin
                merged_c[b*8 +: 8] = mem_wdata256[b*8 +: 8];
            end
        end
    end

    // Victim: lowest invalid way, else follow the pLRU tree from the root
    always_comb begin
        int unsigned node;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_q[addr_idx][w]) begin
                inv_found_c = 1'b1;
                inv_way_c   = way_w'(w);
            end
        end
        node = 0;
        for (int l = 0; l < way_w; l++) begin
            node = 2 * node + 1 + 32'(lru_cur_c[way_w'(node)]);
        end
        lru_way_c = way_w'(node - lru_w);
        victim_c  = inv_found_c ? inv_way_c : lru_way_c;
    end

    // Point every node on the hit path away from the accessed way
    always_comb begin
        int unsigned node;
        logic        dir;
        lru_upd_c = lru_cur_c;
        node      = 0;
        for (int l = 0; l < way_w; l++) begin
            dir                        = hit_way_c[way_w - 1 - l];
            lru_upd_c[way_w'(node)]    = ~dir;
            node                       = 2 * node + 1 + 32'(dir);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            victim_q <= victim_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        victim_d     = victim_q;
        mem_resp     = 1'b0;
        mem_rdata256 = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        line_we      = 1'b0;
        line_way     = victim_q;
        line_wdata   = pmem_rdata;
        fill_done    = 1'b0;
        hit_upd      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    write_d = mem_write;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hit_c) begin
                    mem_resp = 1'b1;
                    hit_upd  = 1'b1;
                    if (write_q) begin
                        line_we    = 1'b1;
                        line_way   = hit_way_c;
                        line_wdata = merged_c;
                    end else begin
                        mem_rdata256 = hit_line_c;
                    end
                    state_d = IDLE;
                end else begin
                    victim_d = victim_c;
                    state_d  = (valid_q[addr_idx][victim_c] && dirty_q[addr_idx][victim_c])
                               ? WB : FILL;
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[addr_idx][victim_q], addr_idx, {s_offset{1'b0}}};
                pmem_wdata   = data_q[addr_idx][victim_q];
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {addr_tag, addr_idx, {s_offset{1'b0}}};
                if (pmem_resp) begin
                    line_we   = 1'b1;
                    fill_done = 1'b1;
                    state_d   = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line data and tags carry no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[addr_idx][line_way] <= line_wdata;
        end
        if (fill_done) begin
            tag_q[addr_idx][victim_q] <= addr_tag;
        end
    end

    // Valid, dirty and pLRU metadata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= '0;
            end
        end else begin
            if (fill_done) begin
                valid_q[addr_idx][victim_q] <= 1'b1;
                dirty_q[addr_idx][victim_q] <= 1'b0;
            end
            if (hit_upd) begin
                lru_q[addr_idx] <= lru_upd_c;
                if (write_q) begin
                    dirty_q[addr_idx][hit_way_c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
module tb_assoc_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_wdata256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    assoc_cache dut (
        .clk                (clk),
        .rst                (rst),
        .mem_address        (mem_address),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_byte_enable256 (mem_byte_enable256),
        .mem_wdata256       (mem_wdata256),
        .mem_rdata256       (mem_rdata256),
        .mem_resp           (mem_resp),
        .pmem_address       (pmem_address),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_wdata         (pmem_wdata),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Physical memory behind the cache, and the CPU-visible memory image
    logic [255:0] phys   [logic [31:0]];
    logic [255:0] golden [logic [31:0]];

    // Reference cache state: 8 sets x 4 ways, 3 tree bits per set
    bit          rv  [8][4];
    bit          rdt [8][4];
    logic [23:0] rt  [8][4];
    bit          rp  [8][3];

    // Memory transactions seen during one request
    bit           ev_w  [$];
    logic [31:0]  ev_a  [$];
    logic [255:0] ev_d  [$];
    int           ev_c  [$];
    int           ev_rc [$];

    int           cyc;
    bit           busy;
    int           cnt;
    int           fixed_delay;
    bit           both_seen;
    bit           leak_seen;
    bit           last_hit;
    logic [255:0] last_rd;

    function automatic logic [255:0] init_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = a * 32'h9E37_79B1 + 32'(k) * 32'h0101_0101;
        return l;
    endfunction

    function automatic logic [255:0] phys_get(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_line(a);
    endfunction

    function automatic logic [255:0] golden_get(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : init_line(a);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                rv[s][w]  = 1'b0;
                rdt[s][w] = 1'b0;
            end
            for (int n = 0; n < 3; n++) rp[s][n] = 1'b0;
        end
        golden = phys;
    endtask

    // Walk root->leaf; each node on the path points away from the used way
    task automatic model_touch(input int s, input int way);
        int node = 0;
        for (int l = 0; l < 2; l++) begin
            int d = (way >> (1 - l)) & 1;
            rp[s][node] = (d == 0);
            node = 2 * node + 1 + d;
        end
    endtask

    function automatic int model_victim(input int s);
        int node = 0;
        for (int w = 0; w < 4; w++) if (!rv[s][w]) return w;
        for (int l = 0; l < 2; l++) node = 2 * node + 1 + int'(rp[s][node]);
        return node - 3;
    endfunction

    // Acts as physical memory for one negedge and watches output hygiene
    task automatic step();
        if (pmem_read && pmem_write) both_seen = 1'b1;
        if (!pmem_read && !pmem_write && (pmem_address != 32'h0 || pmem_wdata != '0)) leak_seen = 1'b1;
        if (!mem_resp && mem_rdata256 != '0) leak_seen = 1'b1;
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            busy      = 1'b0;
        end
        if ((pmem_read || pmem_write) && !busy) begin
            busy = 1'b1;
            cnt  = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
            ev_w.push_back(pmem_write);
            ev_a.push_back(pmem_address);
            ev_d.push_back(pmem_wdata);
            ev_c.push_back(cyc);
        end
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                pmem_resp = 1'b1;
                ev_rc.push_back(cyc);
                if (pmem_write) phys[pmem_address] = pmem_wdata;
                else            pmem_rdata = phys_get(pmem_address);
            end
        end
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] be,
                          input logic [255:0] wd, input string tag);
        logic [31:0]  la;
        int           s;
        logic [23:0]  tg;
        int           way;
        int           vic;
        bit           exp_wb;
        logic [31:0]  wb_addr;
        logic [255:0] wb_data;
        logic [255:0] exp_rd;
        bit           got;
        logic [255:0] nl;

        la  = {addr[31:5], 5'b0};
        s   = int'(addr[7:5]);
        tg  = addr[31:8];
        way = -1;
        for (int w = 0; w < 4; w++) if (rv[s][w] && rt[s][w] == tg) way = w;
        last_hit = (way >= 0);
        vic      = last_hit ? way : model_victim(s);
        exp_wb   = !last_hit && rv[s][vic] && rdt[s][vic];
        wb_addr  = {rt[s][vic], 3'(s), 5'b0};
        wb_data  = golden_get(wb_addr);
        exp_rd   = golden_get(la);

        ev_w.delete(); ev_a.delete(); ev_d.delete(); ev_c.delete(); ev_rc.delete();
        both_seen = 1'b0;
        leak_seen = 1'b0;
        busy      = 1'b0;
        cyc       = 0;
        got       = 1'b0;

        @(negedge clk);
        mem_address        = addr;
        mem_read           = !wr;
        mem_write          = wr;
        mem_byte_enable256 = be;
        mem_wdata256       = wd;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            got     = mem_resp;
            last_rd = mem_rdata256;
            step();
            if (got) break;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;

        chk({tag, " resp"}, 256'(got), 256'(1));
        if (!wr) chk({tag, " rdata"}, last_rd, exp_rd);
        chk({tag, " pmem rd+wr overlap"}, 256'(both_seen), 256'(0));
        chk({tag, " outputs nonzero when idle"}, 256'(leak_seen), 256'(0));
        if (last_hit) begin
            chk({tag, " hit latency"}, 256'(cyc), 256'(1));
            chk({tag, " hit pmem events"}, 256'(ev_a.size()), 256'(0));
        end else begin
            chk({tag, " miss pmem events"}, 256'(ev_a.size()), 256'(exp_wb ? 2 : 1));
            if (ev_a.size() == (exp_wb ? 2 : 1) && ev_rc.size() == ev_a.size()) begin
                chk({tag, " first pmem cycle"}, 256'(ev_c[0]), 256'(2));
                if (exp_wb) begin
                    chk({tag, " wb is write"}, 256'(ev_w[0]), 256'(1));
                    chk({tag, " wb addr"}, 256'(ev_a[0]), 256'(wb_addr));
                    chk({tag, " wb data"}, ev_d[0], wb_data);
                    chk({tag, " fill after wb"}, 256'(ev_c[1]), 256'(ev_rc[0] + 1));
                end
                chk({tag, " fill is read"}, 256'(ev_w[ev_w.size()-1]), 256'(0));
                chk({tag, " fill addr"}, 256'(ev_a[ev_a.size()-1]), 256'(la));
                chk({tag, " miss latency"}, 256'(cyc), 256'(ev_rc[ev_rc.size()-1] + 1));
            end
        end

        if (!last_hit) begin
            rv[s][vic]  = 1'b1;
            rdt[s][vic] = 1'b0;
            rt[s][vic]  = tg;
        end
        model_touch(s, vic);
        if (wr) begin
            rdt[s][vic] = 1'b1;
            nl = golden_get(la);
            for (int b = 0; b < 32; b++) if (be[b]) nl[8*b +: 8] = wd[8*b +: 8];
            golden[la] = nl;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [255:0] wd;
        bit           saw_resp;
        bit           saw_fill;

        rst                = 1'b1;
        mem_address        = '0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_byte_enable256 = '0;
        mem_wdata256       = '0;
        pmem_rdata         = '0;
        pmem_resp          = 1'b0;
        fixed_delay        = 3;
        model_reset();

        repeat (3) @(negedge clk);
        chk("reset mem_resp", 256'(mem_resp), 256'(0));
        chk("reset pmem_read", 256'(pmem_read), 256'(0));
        chk("reset pmem_write", 256'(pmem_write), 256'(0));
        chk("reset mem_rdata256", mem_rdata256, 256'(0));
        chk("reset pmem_address", 256'(pmem_address), 256'(0));
        chk("reset pmem_wdata", pmem_wdata, 256'(0));
        rst = 1'b0;

        // Cold read, write hit, read back
        do_req(1'b0, 32'h0000_0040, '0, '0, "cold read 0x40");
        chk("cold read line A", last_rd, init_line(32'h40));
        wd = '0;
        wd[31:0] = 32'hDEAD_BEEF;
        do_req(1'b1, 32'h0000_0040, 32'h0000_000F, wd, "write hit 0x40");
        do_req(1'b0, 32'h0000_0040, '0, '0, "read merged 0x40");
        chk("merged low word", 256'(last_rd[31:0]), 256'(32'hDEAD_BEEF));
        chk("merged upper bytes", 256'(last_rd[255:32]), 256'(init_line(32'h40) >> 32));

        // Fill ways 1..3 of set 2, then the pLRU victim (way 0, dirty) is evicted
        do_req(1'b0, 32'h0000_0140, '0, '0, "fill 0x140");
        do_req(1'b0, 32'h0000_0240, '0, '0, "fill 0x240");
        do_req(1'b0, 32'h0000_0340, '0, '0, "fill 0x340");
        do_req(1'b0, 32'h0000_0440, '0, '0, "evict 0x440");
        chk("evict count", 256'(ev_a.size()), 256'(2));
        if (ev_a.size() == 2) begin
            chk("evict wb first", 256'(ev_w[0]), 256'(1));
            chk("evict wb addr 0x40", 256'(ev_a[0]), 256'(32'h40));
            chk("evict fill addr 0x440", 256'(ev_a[1]), 256'(32'h440));
        end
        do_req(1'b0, 32'h0000_0140, '0, '0, "hit 0x140 kept");
        chk("0x140 was hit", 256'(last_hit), 256'(1));

        // Clean eviction in set 1
        do_req(1'b0, 32'h0000_0020, '0, '0, "set1 fill 0x020");
        do_req(1'b0, 32'h0000_0120, '0, '0, "set1 fill 0x120");
        do_req(1'b0, 32'h0000_0220, '0, '0, "set1 fill 0x220");
        do_req(1'b0, 32'h0000_0320, '0, '0, "set1 fill 0x320");
        do_req(1'b0, 32'h0000_0420, '0, '0, "clean evict 0x420");
        chk("clean evict single read", 256'(ev_a.size()), 256'(1));
        if (ev_a.size() == 1) chk("clean evict no write", 256'(ev_w[0]), 256'(0));

        // Bring 0x40 back, then reset in the middle of a fill
        do_req(1'b0, 32'h0000_0040, '0, '0, "reload 0x40");
        @(negedge clk);
        mem_address = 32'h0000_0540;
        mem_read    = 1'b1;
        busy        = 1'b0;
        cyc         = 0;
        saw_resp    = 1'b0;
        saw_fill    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) saw_resp = 1'b1;
            if (pmem_read) begin
                saw_fill = 1'b1;
                break;
            end
            step();
        end
        chk("midfill pmem_read seen", 256'(saw_fill), 256'(1));
        rst = 1'b1;
        #1;
        chk("midfill pmem_read dropped", 256'(pmem_read), 256'(0));
        chk("midfill pmem_write low", 256'(pmem_write), 256'(0));
        chk("midfill pmem_address cleared", 256'(pmem_address), 256'(0));
        chk("midfill mem_resp low", 256'(mem_resp | saw_resp), 256'(0));
        mem_read  = 1'b0;
        pmem_resp = 1'b0;
        busy      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_req(1'b0, 32'h0000_0040, '0, '0, "post-reset 0x40");
        chk("post-reset 0x40 misses", 256'(last_hit), 256'(0));
        if (ev_a.size() >= 1) chk("post-reset fill addr", 256'(ev_a[0]), 256'(32'h40));

        // Randomised traffic against the reference model
        fixed_delay = 0;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            bit          w;
            for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
            a = {24'($urandom_range(0, 5)), 3'($urandom_range(0, 3)), 5'($urandom)};
            w = $urandom_range(0, 1) == 1;
            do_req(w, a, $urandom, wd, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
